// File: rtl/cpu_boot_pkg.sv
// -----------------------------------------------------------------------------
// cpu_boot_pkg
// Shared definitions for the CPU boot sequencer slice.
//   - boot_state_t : sequencer FSM states
//   - TGT_*        : target memory indices used on in_sel
//   - sel_w()      : width of the target-select field for a given target count
// No ports (package).
// -----------------------------------------------------------------------------
package cpu_boot_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_DONE,
        S_ERR
    } boot_state_t;

    localparam int TGT_REGBANK = 0;
    localparam int TGT_INSTMEM = 1;
    localparam int TGT_DATAMEM = 2;

    // A single target still needs a one-bit select so the port never collapses.
    function automatic int sel_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/cpu_boot_addr_ctr.sv
// -----------------------------------------------------------------------------
// cpu_boot_addr_ctr
// Word-address counter for one target memory, with overflow detection.
// Ports:
//   clk      in   system clock
//   rst      in   asynchronous active-high reset
//   i_clear  in   restart the counter at address 0 (new load session)
//   i_inc    in   a word was written at o_addr; advance
//   o_addr   out  address the next word for this target will use
//   o_full   out  all 2**ADDR_W addresses have been written this session
// -----------------------------------------------------------------------------
module cpu_boot_addr_ctr #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_clear,
    input  logic              i_inc,
    output logic [ADDR_W-1:0] o_addr,
    output logic              o_full
);

    logic [ADDR_W-1:0] r_addr;
    logic              r_full;

    // The address wraps back to zero after the last location; r_full remembers
    // that the wrap happened so a further write can be flagged as overflow.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_addr <= '0;
            r_full <= 1'b0;
        end else if (i_clear) begin
            r_addr <= '0;
            r_full <= 1'b0;
        end else if (i_inc) begin
            if (r_addr == {ADDR_W{1'b1}}) begin
                r_full <= 1'b1;
            end
            r_addr <= r_addr + 1'b1;
        end
    end

    assign o_addr = r_addr;
    assign o_full = r_full;

endmodule

// File: rtl/cpu_boot_sequencer.sv
// -----------------------------------------------------------------------------
// cpu_boot_sequencer
// Loads the CPU's target memories from a word stream while the CPU is held,
// then releases the CPU for RUN_CYCLES cycles and reports done or err.
// Optional feature macro: CPU_BOOT_CHECKSUM_EN -- the in_last word becomes a
// checksum (sum of all earlier data words) instead of a data word.
// Ports:
//   clk_CPU, rst_CPU        clock / async active-high reset
//   start                   begin a load session (IDLE/DONE/ERR only)
//   in_valid/in_ready       stream handshake (ready only in LOAD)
//   in_data/in_sel/in_last  stream word, target index, end-of-session marker
//   wr_en/wr_addr/wr_data   registered write port, wr_en one-hot per target
//   cpu_run                 CPU enable during RUN
//   cycle_cnt               RUN cycles elapsed
//   done / err              run finished / session aborted
// -----------------------------------------------------------------------------
module cpu_boot_sequencer
    import cpu_boot_pkg::*;
#(
    parameter  int DATA_W     = 32,
    parameter  int ADDR_W     = 8,
    parameter  int N_TARGETS  = 3,
    parameter  int RUN_CYCLES = 20,
    localparam int SEL_W      = sel_w(N_TARGETS)
) (
    input  logic                 clk_CPU,
    input  logic                 rst_CPU,
    input  logic                 start,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [DATA_W-1:0]    in_data,
    input  logic [SEL_W-1:0]     in_sel,
    input  logic                 in_last,
    output logic [N_TARGETS-1:0] wr_en,
    output logic [ADDR_W-1:0]    wr_addr,
    output logic [DATA_W-1:0]    wr_data,
    output logic                 cpu_run,
    output logic [31:0]          cycle_cnt,
    output logic                 done,
    output logic                 err
);

    boot_state_t          r_state;
    boot_state_t          w_nextState;
    logic                 w_clear;
    logic                 w_write;
    logic                 w_selOk;
    logic                 w_tgtFull;
    logic [N_TARGETS-1:0] w_selOneHot;
    logic [N_TARGETS-1:0] w_ctrInc;
    logic [N_TARGETS-1:0] w_ctrFull;
    logic [ADDR_W-1:0]    w_ctrAddr [N_TARGETS];
    logic [ADDR_W-1:0]    w_selAddr;

    logic [N_TARGETS-1:0] r_wrEn;
    logic [ADDR_W-1:0]    r_wrAddr;
    logic [DATA_W-1:0]    r_wrData;
    logic [31:0]          r_cycleCnt;
`ifdef CPU_BOOT_CHECKSUM_EN
    logic [DATA_W-1:0]    r_sum;
`endif

    // One independent address counter per target memory.
    assign w_ctrInc = w_write ? w_selOneHot : '0;

    for (genvar g = 0; g < N_TARGETS; g++) begin : g_ctr
        cpu_boot_addr_ctr #(.ADDR_W(ADDR_W)) u_ctr (
            .clk     (clk_CPU),
            .rst     (rst_CPU),
            .i_clear (w_clear),
            .i_inc   (w_ctrInc[g]),
            .o_addr  (w_ctrAddr[g]),
            .o_full  (w_ctrFull[g])
        );
    end

    // Decode in_sel into a one-hot and pick that target's counter state.
    // An out-of-range select leaves the one-hot empty, which marks it invalid.
    always_comb begin
        w_selOneHot = '0;
        w_selAddr   = '0;
        w_tgtFull   = 1'b0;
        for (int i = 0; i < N_TARGETS; i++) begin
            if (int'(in_sel) == i) begin
                w_selOneHot[i] = 1'b1;
                w_selAddr      = w_ctrAddr[i];
                w_tgtFull      = w_ctrFull[i];
            end
        end
    end

    assign w_selOk = |w_selOneHot;

    // FSM state register.
    always_ff @(posedge clk_CPU or posedge rst_CPU) begin
        if (rst_CPU) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state logic. Words are only consumed in LOAD, so in_valid elsewhere
    // (including alongside start) has no effect. A bad select or a write past
    // the target's depth aborts the session without writing.
    always_comb begin
        w_nextState = r_state;
        w_clear     = 1'b0;
        w_write     = 1'b0;
        case (r_state)
            S_IDLE, S_DONE, S_ERR: begin
                if (start) begin
                    w_nextState = S_LOAD;
                    w_clear     = 1'b1;
                end
            end
            S_LOAD: begin
                if (in_valid) begin
`ifdef CPU_BOOT_CHECKSUM_EN
                    if (in_last) begin
                        w_nextState = (in_data == r_sum) ? S_RUN : S_ERR;
                    end else if (!w_selOk || w_tgtFull) begin
                        w_nextState = S_ERR;
                    end else begin
                        w_write = 1'b1;
                    end
`else
                    if (!w_selOk || w_tgtFull) begin
                        w_nextState = S_ERR;
                    end else begin
                        w_write = 1'b1;
                        if (in_last) begin
                            w_nextState = S_RUN;
                        end
                    end
`endif
                end
            end
            S_RUN: begin
                if (r_cycleCnt == 32'(RUN_CYCLES - 1)) begin
                    w_nextState = S_DONE;
                end
            end
            default: w_nextState = S_IDLE;
        endcase
    end

    // Registered write port and run cycle counter. Address/data hold their
    // last value between writes; only wr_en pulses.
    always_ff @(posedge clk_CPU or posedge rst_CPU) begin
        if (rst_CPU) begin
            r_wrEn     <= '0;
            r_wrAddr   <= '0;
            r_wrData   <= '0;
            r_cycleCnt <= '0;
        end else begin
            r_wrEn <= w_write ? w_selOneHot : '0;
            if (w_write) begin
                r_wrAddr <= w_selAddr;
                r_wrData <= in_data;
            end
            if (w_clear) begin
                r_cycleCnt <= '0;
            end else if (r_state == S_RUN) begin
                r_cycleCnt <= r_cycleCnt + 32'd1;
            end
        end
    end

`ifdef CPU_BOOT_CHECKSUM_EN
    // Running sum of every data word written this session; the checksum word
    // itself is never written, so it is never added.
    always_ff @(posedge clk_CPU or posedge rst_CPU) begin
        if (rst_CPU) begin
            r_sum <= '0;
        end else if (w_clear) begin
            r_sum <= '0;
        end else if (w_write) begin
            r_sum <= r_sum + in_data;
        end
    end
`endif

    assign in_ready  = (r_state == S_LOAD);
    assign cpu_run   = (r_state == S_RUN);
    assign done      = (r_state == S_DONE);
    assign err       = (r_state == S_ERR);
    assign wr_en     = r_wrEn;
    assign wr_addr   = r_wrAddr;
    assign wr_data   = r_wrData;
    assign cycle_cnt = r_cycleCnt;

endmodule

// File: tb/tb_cpu_boot_sequencer.sv
// -----------------------------------------------------------------------------
// tb_cpu_boot_sequencer
// Directed bench for cpu_boot_sequencer. The main instance uses the default
// parameters; a second instance with ADDR_W=2 exercises target overflow.
// Honours CPU_BOOT_CHECKSUM_EN to choose between the plain interleaved load
// and the checksum sessions.
// -----------------------------------------------------------------------------
module tb_cpu_boot_sequencer;

    logic        clk_CPU = 1'b0;
    logic        rst_CPU;

    logic        start, in_valid, in_last;
    logic [31:0] in_data;
    logic [1:0]  in_sel;
    logic        in_ready, cpu_run, done, err;
    logic [2:0]  wr_en;
    logic [7:0]  wr_addr;
    logic [31:0] wr_data, cycle_cnt;

    logic        s2Start, s2Valid, s2Last;
    logic [31:0] s2Data;
    logic [1:0]  s2Sel;
    logic        s2Ready, s2Run, s2Done, s2Err;
    logic [2:0]  s2WrEn;
    logic [1:0]  s2WrAddr;
    logic [31:0] s2WrData, s2CycleCnt;

    int vectors     = 0;
    int miscompares = 0;
    int runCount;
    int writeCount;
    logic wrSeen;

`ifndef CPU_BOOT_CHECKSUM_EN
    logic [1:0]  ilSel  [6] = '{2'd1, 2'd2, 2'd1, 2'd2, 2'd1, 2'd0};
    logic [31:0] ilData [6] = '{32'h20080005, 32'hAAAA0001, 32'h20090003,
                                32'hAAAA0002, 32'h01095020, 32'hC0DE0000};
    logic [31:0] ilEn   [6] = '{32'd2, 32'd4, 32'd2, 32'd4, 32'd2, 32'd1};
    logic [31:0] ilAddr [6] = '{32'd0, 32'd0, 32'd1, 32'd1, 32'd2, 32'd0};
`endif

    always #5 clk_CPU = ~clk_CPU;

    cpu_boot_sequencer dut (
        .clk_CPU   (clk_CPU),
        .rst_CPU   (rst_CPU),
        .start     (start),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_sel    (in_sel),
        .in_last   (in_last),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .cpu_run   (cpu_run),
        .cycle_cnt (cycle_cnt),
        .done      (done),
        .err       (err)
    );

    cpu_boot_sequencer #(.ADDR_W(2)) dutSmall (
        .clk_CPU   (clk_CPU),
        .rst_CPU   (rst_CPU),
        .start     (s2Start),
        .in_valid  (s2Valid),
        .in_ready  (s2Ready),
        .in_data   (s2Data),
        .in_sel    (s2Sel),
        .in_last   (s2Last),
        .wr_en     (s2WrEn),
        .wr_addr   (s2WrAddr),
        .wr_data   (s2WrData),
        .cpu_run   (s2Run),
        .cycle_cnt (s2CycleCnt),
        .done      (s2Done),
        .err       (s2Err)
    );

    // Step to just after the next rising edge so registered outputs are settled.
    task automatic tick;
        @(posedge clk_CPU);
        #1;
    endtask

    task automatic applyStimulus(input logic s, input logic v, input logic [31:0] d,
                                 input logic [1:0] sel, input logic l);
        start    = s;
        in_valid = v;
        in_data  = d;
        in_sel   = sel;
        in_last  = l;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    initial begin
        rst_CPU = 1'b1;
        applyStimulus(1'b0, 1'b0, 32'h0, 2'd0, 1'b0);
        s2Start = 1'b0; s2Valid = 1'b0; s2Data = '0; s2Sel = '0; s2Last = 1'b0;

        // Outputs during reset
        #12;
        checkOutput("rst_in_ready",  32'(in_ready),  32'd0);
        checkOutput("rst_wr_en",     32'(wr_en),     32'd0);
        checkOutput("rst_cpu_run",   32'(cpu_run),   32'd0);
        checkOutput("rst_cycle_cnt", cycle_cnt,      32'd0);
        checkOutput("rst_done",      32'(done),      32'd0);
        checkOutput("rst_err",       32'(err),       32'd0);
        rst_CPU = 1'b0;
        tick();

        // in_valid in IDLE, then together with start: nothing consumed
        applyStimulus(1'b0, 1'b1, 32'hDEADBEEF, 2'd0, 1'b1);
        tick();
        checkOutput("idle_valid_wr_en", 32'(wr_en),    32'd0);
        checkOutput("idle_valid_ready", 32'(in_ready), 32'd0);
        applyStimulus(1'b1, 1'b1, 32'hDEADBEEF, 2'd0, 1'b1);
        checkOutput("start_cycle_ready", 32'(in_ready), 32'd0);
        tick();
        checkOutput("start_valid_wr_en", 32'(wr_en),    32'd0);
        checkOutput("load_ready",        32'(in_ready), 32'd1);
        applyStimulus(1'b0, 1'b0, 32'h0, 2'd0, 1'b0);

`ifndef CPU_BOOT_CHECKSUM_EN
        // Interleaved load across the three targets, last word on target 0
        for (int k = 0; k < 6; k++) begin
            applyStimulus(1'b0, 1'b1, ilData[k], ilSel[k], k == 5);
            tick();
            checkOutput($sformatf("il_wr_en%0d", k),   32'(wr_en),   ilEn[k]);
            checkOutput($sformatf("il_wr_addr%0d", k), 32'(wr_addr), ilAddr[k]);
            checkOutput($sformatf("il_wr_data%0d", k), wr_data,      ilData[k]);
        end
        // Keep in_valid high during RUN: must not produce writes
        applyStimulus(1'b0, 1'b1, 32'h0BADF00D, 2'd0, 1'b0);
        checkOutput("run_ready",   32'(in_ready),  32'd0);
        checkOutput("run_cnt0",    cycle_cnt,      32'd0);
        runCount = 0;
        wrSeen   = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (done) break;
            if (cpu_run) runCount++;
            tick();
            if (wr_en != 3'b000) wrSeen = 1'b1;
        end
        checkOutput("run_length",    32'(runCount), 32'd20);
        checkOutput("done_flag",     32'(done),     32'd1);
        checkOutput("done_cycles",   cycle_cnt,     32'd20);
        checkOutput("done_cpu_run",  32'(cpu_run),  32'd0);
        checkOutput("run_no_writes", 32'(wrSeen),   32'd0);
        applyStimulus(1'b0, 1'b0, 32'h0, 2'd0, 1'b0);
        tick();
`else
        // Checksum session 1: data 1,2,3 then checksum 6 (select ignored)
        for (int k = 0; k < 3; k++) begin
            applyStimulus(1'b0, 1'b1, 32'(k + 1), 2'd0, 1'b0);
            tick();
            checkOutput($sformatf("ck_wr_en%0d", k),   32'(wr_en),   32'd1);
            checkOutput($sformatf("ck_wr_addr%0d", k), 32'(wr_addr), 32'(k));
        end
        applyStimulus(1'b0, 1'b1, 32'd6, 2'd3, 1'b1);
        tick();
        checkOutput("ck_last_no_write", 32'(wr_en),   32'd0);
        checkOutput("ck_run",           32'(cpu_run), 32'd1);
        applyStimulus(1'b0, 1'b0, 32'h0, 2'd0, 1'b0);
        for (int k = 0; k < 40; k++) begin
            if (done) break;
            tick();
        end
        checkOutput("ck_done", 32'(done), 32'd1);

        // Checksum session 2: wrong checksum 7
        applyStimulus(1'b1, 1'b0, 32'h0, 2'd0, 1'b0);
        tick();
        writeCount = 0;
        for (int k = 0; k < 3; k++) begin
            applyStimulus(1'b0, 1'b1, 32'(k + 1), 2'd0, 1'b0);
            tick();
            if (wr_en != 3'b000) writeCount++;
        end
        applyStimulus(1'b0, 1'b1, 32'd7, 2'd0, 1'b1);
        tick();
        if (wr_en != 3'b000) writeCount++;
        checkOutput("ck_bad_err",    32'(err),        32'd1);
        checkOutput("ck_bad_run",    32'(cpu_run),    32'd0);
        checkOutput("ck_bad_writes", 32'(writeCount), 32'd3);
        applyStimulus(1'b0, 1'b0, 32'h0, 2'd0, 1'b0);
        tick();
`endif

        // Bad select aborts the session; a new start recovers
        applyStimulus(1'b1, 1'b0, 32'h0, 2'd0, 1'b0);
        tick();
        checkOutput("bs_ready", 32'(in_ready), 32'd1);
        checkOutput("bs_done",  32'(done),     32'd0);
        applyStimulus(1'b0, 1'b1, 32'h12345678, 2'd3, 1'b0);
        tick();
        checkOutput("bs_err",   32'(err),   32'd1);
        checkOutput("bs_wr_en", 32'(wr_en), 32'd0);
        applyStimulus(1'b0, 1'b0, 32'h0, 2'd0, 1'b0);
        tick();
        tick();
        checkOutput("bs_cpu_run", 32'(cpu_run), 32'd0);
        checkOutput("bs_err_hold", 32'(err),    32'd1);
        applyStimulus(1'b1, 1'b0, 32'h0, 2'd0, 1'b0);
        tick();
        checkOutput("bs_restart_err",   32'(err),      32'd0);
        checkOutput("bs_restart_ready", 32'(in_ready), 32'd1);

        // Reset in the fifth RUN cycle
        applyStimulus(1'b0, 1'b1, 32'h0, 2'd0, 1'b1);
        tick();
        checkOutput("rr_run", 32'(cpu_run), 32'd1);
        applyStimulus(1'b0, 1'b0, 32'h0, 2'd0, 1'b0);
        tick(); tick(); tick(); tick();
        checkOutput("rr_cnt_before", cycle_cnt, 32'd4);
        #2 rst_CPU = 1'b1;
        #1;
        checkOutput("rr_cpu_run", 32'(cpu_run), 32'd0);
        checkOutput("rr_cnt",     cycle_cnt,    32'd0);
        checkOutput("rr_done",    32'(done),    32'd0);
        checkOutput("rr_err",     32'(err),     32'd0);
        #2 rst_CPU = 1'b0;
        tick();
        checkOutput("rr_idle_ready", 32'(in_ready), 32'd0);
        checkOutput("rr_idle_run",   32'(cpu_run),  32'd0);

        // Overflow on the ADDR_W=2 instance: 4 words fit, the 5th aborts
        s2Start = 1'b1;
        tick();
        s2Start = 1'b0;
        for (int k = 0; k < 4; k++) begin
            s2Valid = 1'b1; s2Sel = 2'd0; s2Data = 32'hA0 + 32'(k);
            tick();
            checkOutput($sformatf("ov_wr_en%0d", k),   32'(s2WrEn),   32'd1);
            checkOutput($sformatf("ov_wr_addr%0d", k), 32'(s2WrAddr), 32'(k));
        end
        s2Data = 32'hA4;
        tick();
        checkOutput("ov_err",   32'(s2Err),  32'd1);
        checkOutput("ov_wr_en", 32'(s2WrEn), 32'd0);
        s2Valid = 1'b0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/cpu_boot_sequencer.md
# cpu_boot_sequencer

Parametrised boot sequencer for the MIPS datapath. It replaces the simulation-only preload-then-run sequence with synthesizable RTL. A word stream loads any number of target memories (register bank, instruction memory, data memory, …) through per-target write ports while the CPU is held stopped. It then releases the CPU for a fixed cycle budget and reports completion or error. It sits between an external loader (UART/JTAG bridge or bench driver) and the CPU top.

## Interface
Parameters:
- DATA_W, 32, width of streamed words and write data
- ADDR_W, 8, per-target word-address width (depth 2**ADDR_W)
- N_TARGETS, 3, number of target memories; 0 = register bank, 1 = instruction memory, 2 = data memory
- RUN_CYCLES, 20, CPU clock cycles to run after load (must be ≥1)

Ports (one clock; reset is asynchronous and active-high):
- clk_CPU  in  1  system clock, rising edge
- rst_CPU  in  1  asynchronous active-high reset
- start  in  1  begin a load session (sampled in IDLE/DONE/ERR)
- in_valid  in  1  stream word valid
- in_ready  out  1  sequencer accepts a word
- in_data  in  DATA_W  stream word
- in_sel  in  SEL_W=max(1,$clog2(N_TARGETS))  target index of this word
- in_last  in  1  final word of session
- wr_en  out  N_TARGETS  one-hot write strobe
- wr_addr  out  ADDR_W  write word address
- wr_data  out  DATA_W  write data
- cpu_run  out  1  CPU enable (clock-enable/stall-release)
- cycle_cnt  out  32  cycles elapsed in RUN
- done  out  1  run budget completed
- err  out  1  session aborted

## Operation
- States: IDLE, LOAD, RUN, DONE, ERR. Reset → IDLE. Every output resets to 0; all per-target address counters reset to 0.
- IDLE/DONE/ERR: start=1 → LOAD. All per-target counters, cycle_cnt, done and err are cleared on the transition.
- LOAD: in_ready=1. A word is accepted on in_valid&in_ready.
  - Accepted word with in_sel<N_TARGETS: write to that target at that target's counter, then increment the counter. Targets load independently and interleave freely.
  - in_sel≥N_TARGETS → ERR. No write.
  - Write to a target whose counter already wrapped past 2**ADDR_W-1 (the depth+1-th word) → ERR. No write. Exactly 2**ADDR_W words per target is legal.
  - Accepted in_last with no error → RUN.
- RUN: cpu_run=1. cycle_cnt increments once per cycle. After RUN_CYCLES cycles of cpu_run=1 → DONE. start is ignored.
- DONE: done=1, cpu_run=0, cycle_cnt holds RUN_CYCLES.
- ERR: err=1. cpu_run stays 0. No further writes.
- in_valid outside LOAD is ignored. No word is consumed.

## Timing
- in_ready is a registered state decode: 1 from the cycle after start is sampled until the cycle after the in_last handshake.
- Write port is registered. wr_en/wr_addr/wr_data appear one cycle after the handshake and are valid for exactly one cycle. wr_en=0 otherwise. wr_addr/wr_data hold their last value when idle.
- in_last handshake at cycle t gives: last write at t+1, cpu_run=1 from t+1 through t+RUN_CYCLES, done=1 from t+RUN_CYCLES+1.
- err rises the cycle after the offending handshake.
- Reset mid-session clears everything immediately (async). Outputs are 0 during reset.
- start and in_valid in the same cycle from IDLE: start is taken, the word is not consumed (in_ready=0 that cycle).

## Configuration
- CPU_BOOT_CHECKSUM_EN defined: the word accepted with in_last is a checksum and is not written. It must equal the mod-2**DATA_W sum of all previously accepted data words of the session. Mismatch → ERR instead of RUN. Its in_sel is ignored.
- Undefined: the in_last word is an ordinary data word, written like any other. There is no check.

## Structure
- Shared package cpu_boot_pkg holds:
  - the state enum
  - target index constants (TGT_REGBANK=0, TGT_INSTMEM=1, TGT_DATAMEM=2)
  - the SEL_W helper
- One natural sub-module: cpu_boot_addr_ctr, a single-target address counter with wrap detection, instantiated N_TARGETS times via generate.

## Test plan
- Interleaved load: 3 words to target 1 (0x20080005, 0x20090003, 0x01095020), 2 to target 2, last on target 0 → wr_en pulses at addrs 0,1,2 / 0,1 / 0 with matching data. cpu_run is high exactly 20 cycles, then done=1 and cycle_cnt=20.
- Bad select: in_sel=3 with N_TARGETS=3 → err=1 next cycle, no wr_en, cpu_run never asserts. A following start → LOAD with err cleared.
- Overflow with ADDR_W=2: 4 words to target 0 are accepted at addrs 0..3. The 5th → ERR with no write.
- Reset at cycle 5 of RUN → cpu_run, done, err, cycle_cnt all 0 asynchronously. State IDLE after release.
- Backpressure: in_valid held high before start and during RUN → no writes, no consumption.
- CPU_BOOT_CHECKSUM_EN: data 1,2,3 then last=6 → RUN. The same session with last=7 → err=1, and only 3 writes occur.
